// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the memory word into IR and hands it to decode over valid/ready.
// Optional perf counters are compiled in with FETCH_PERF_EN; otherwise fetch_cnt/stall_cnt read as zero.
module if_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_addr,
    input  logic               halt_req,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic               halted,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

    state_t             state_q,    state_d;
    logic [ADDR_W-1:0]  pc_q,       pc_d;
    logic [INSTR_W-1:0] ir_q,       ir_d;
    logic [ADDR_W-1:0]  ir_pc_q,    ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q,   halted_d;
    logic               load;
    logic               halting;
    logic               backpressure;

    assign halting      = halt_req || (state_q == HALT);
    assign backpressure = ir_valid_q && !ir_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        load       = 1'b0;
        if (halting) begin
            // A pending word may still drain to decode, but nothing new is fetched.
            state_d  = HALT;
            halted_d = 1'b1;
            if (ir_ready) ir_valid_d = 1'b0;
        end else if (br_taken) begin
            state_d    = FETCH;
            pc_d       = br_addr;
            ir_valid_d = 1'b0;
        end else if (stall) begin
            if (ir_ready) ir_valid_d = 1'b0;
            state_d = backpressure ? HOLD : FETCH;
        end else if (backpressure) begin
            state_d = HOLD;
        end else begin
            state_d    = FETCH;
            load       = 1'b1;
            ir_d       = im_data;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign im_addr  = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Both counters saturate rather than wrap so a long run never reads as a short one.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (load && fetch_cnt_q != 16'hFFFF) fetch_cnt_d = fetch_cnt_q + 16'd1;
        if (!halting && (stall || backpressure) && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stream, backpressure, branch, stall, PC wrap, halt and async reset.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        stall, br_taken, halt_req, ir_ready;
    logic [15:0] br_addr;

    logic [15:0] im_addr,  ir_pc,  fetch_cnt,  stall_cnt;
    logic [31:0] im_data,  ir;
    logic        ir_valid, halted;

    logic [15:0] im_addr2, ir_pc2, fetch_cnt2, stall_cnt2;
    logic [31:0] im_data2, ir2;
    logic        ir_valid2, halted2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Instruction memory: the word at address a is 32'hC0DE_0000 | a.
    assign im_data  = 32'hC0DE_0000 | {16'h0000, im_addr};
    assign im_data2 = 32'hC0DE_0000 | {16'h0000, im_addr2};

    if_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_f(rst_f), .stall(stall), .br_taken(br_taken), .br_addr(br_addr),
        .halt_req(halt_req), .im_addr(im_addr), .im_data(im_data), .ir(ir), .ir_pc(ir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .halted(halted),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    if_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_f(rst_f), .stall(stall), .br_taken(br_taken), .br_addr(br_addr),
        .halt_req(halt_req), .im_addr(im_addr2), .im_data(im_data2), .ir(ir2), .ir_pc(ir_pc2),
        .ir_valid(ir_valid2), .ir_ready(ir_ready), .halted(halted2),
        .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_f    = 1'b0;
        stall    = 1'b0;
        br_taken = 1'b0;
        br_addr  = 16'h0000;
        halt_req = 1'b0;
        ir_ready = 1'b1;
        #12;
        check("rst_pc",     32'(im_addr),  32'h0);
        check("rst_ir",     ir,            32'h0);
        check("rst_ir_pc",  32'(ir_pc),    32'h0);
        check("rst_valid",  32'(ir_valid), 32'h0);
        check("rst_halted", 32'(halted),   32'h0);
        check("rst_pc_wrap", 32'(im_addr2), 32'hFFFF);
        rst_f = 1'b1;

        // Stream four words with decode always ready.
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stream_ir%0d", k),    ir,            32'hC0DE_0000 | k);
            check($sformatf("stream_irpc%0d", k),  32'(ir_pc),    32'(k));
            check($sformatf("stream_valid%0d", k), 32'(ir_valid), 32'h1);
            if (k == 0) check("wrap_first_irpc",  32'(ir_pc2), 32'hFFFF);
            if (k == 1) check("wrap_second_irpc", 32'(ir_pc2), 32'h0000);
        end
        check("stream_pc4", 32'(im_addr), 32'h4);

        // Decode refuses for three edges: everything holds.
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("bp_ir",    ir,            32'hC0DE_0003);
        check("bp_irpc",  32'(ir_pc),    32'h3);
        check("bp_pc",    32'(im_addr),  32'h4);
        check("bp_valid", 32'(ir_valid), 32'h1);
`ifdef FETCH_PERF_EN
        check("bp_stall_cnt", 32'(stall_cnt), 32'd3);
`else
        check("bp_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        ir_ready = 1'b1;
        tick();
        check("bp_release_ir", ir,           32'hC0DE_0004);
        check("bp_release_pc", 32'(im_addr), 32'h5);

        // Branch from pc=5 to 0x40: flush, then target word two edges after the request.
        br_taken = 1'b1;
        br_addr  = 16'h0040;
        tick();
        br_taken = 1'b0;
        check("br_valid", 32'(ir_valid), 32'h0);
        check("br_pc",    32'(im_addr),  32'h0040);
        check("br_ir_kept", ir,          32'hC0DE_0004);
        tick();
        check("br_target_ir",   ir,            32'hC0DE_0040);
        check("br_target_irpc", 32'(ir_pc),    32'h0040);
        check("br_target_valid", 32'(ir_valid), 32'h1);
`ifdef FETCH_PERF_EN
        check("fetch_cnt", 32'(fetch_cnt), 32'd6);
`else
        check("fetch_cnt", 32'(fetch_cnt), 32'd0);
`endif

        // Branch and stall together, decode not ready: branch wins and discards the word.
        stall    = 1'b1;
        br_taken = 1'b1;
        br_addr  = 16'h0010;
        ir_ready = 1'b0;
        tick();
        br_taken = 1'b0;
        check("brstall_pc",    32'(im_addr),  32'h0010);
        check("brstall_valid", 32'(ir_valid), 32'h0);

        // Stall alone with an empty slot: nothing loads.
        ir_ready = 1'b1;
        tick();
        check("stall_empty_pc",    32'(im_addr),  32'h0010);
        check("stall_empty_valid", 32'(ir_valid), 32'h0);
        stall = 1'b0;
        tick();
        check("unstall_ir", ir,           32'hC0DE_0010);
        check("unstall_pc", 32'(im_addr), 32'h0011);
        stall    = 1'b1;
        ir_ready = 1'b0;
        tick();
        check("stall_hold_valid", 32'(ir_valid), 32'h1);
        check("stall_hold_pc",    32'(im_addr),  32'h0011);
        ir_ready = 1'b1;
        tick();
        check("stall_consume_valid", 32'(ir_valid), 32'h0);
        check("stall_consume_pc",    32'(im_addr),  32'h0011);
        stall = 1'b0;
        tick();
        check("pre_halt_ir", ir, 32'hC0DE_0011);

        // Halt with a pending word that decode is not yet taking.
        halt_req = 1'b1;
        ir_ready = 1'b0;
        tick();
        halt_req = 1'b0;
        check("halt_halted", 32'(halted),   32'h1);
        check("halt_valid",  32'(ir_valid), 32'h1);
        check("halt_pc",     32'(im_addr),  32'h0012);
        tick();
        check("halt_sticky", 32'(halted),   32'h1);
        check("halt_keep_ir", ir,           32'hC0DE_0011);
        ir_ready = 1'b1;
        tick();
        check("halt_drain_valid", 32'(ir_valid), 32'h0);
        tick();
        check("halt_no_fetch_valid", 32'(ir_valid), 32'h0);
        check("halt_no_fetch_pc",    32'(im_addr),  32'h0012);

        // Reset between edges takes effect without a clock.
        #2;
        rst_f = 1'b0;
        #1;
        check("mid_rst_halted", 32'(halted),   32'h0);
        check("mid_rst_pc",     32'(im_addr),  32'h0);
        check("mid_rst_ir",     ir,            32'h0);
        check("mid_rst_irpc",   32'(ir_pc),    32'h0);
        check("mid_rst_valid",  32'(ir_valid), 32'h0);
        check("mid_rst_fcnt",   32'(fetch_cnt), 32'h0);
        check("mid_rst_scnt",   32'(stall_cnt), 32'h0);
        check("mid_rst_pc_wrap", 32'(im_addr2), 32'hFFFF);
        rst_f = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
